// File: rtl/division.sv
// Sequential unsigned divider: restoring long division, one quotient bit per
// clock, with valid/ready handshakes on the operand and result streams.
module division #(
   parameter int unsigned SIZE = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] input_dividen_tdata,
   input  logic            input_dividen_tvalid,
   output logic            input_dividen_tready,
   input  logic [SIZE-1:0] input_divisor_tdata,
   input  logic            input_divisor_tvalid,
   output logic            input_divisor_tready,
   output logic [SIZE-1:0] output_tdata,
   output logic            output_tvalid,
   input  logic            output_tready
);

   localparam int unsigned REM_W = SIZE + 1;
   localparam int unsigned CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [SIZE-1:0]   dividend, dividend_n;
   logic [SIZE-1:0]   divisor, divisor_n;
   logic [REM_W-1:0]  rem, rem_n;
   logic [SIZE-1:0]   quot, quot_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              calc_done, calc_done_n;
   logic [SIZE-1:0]   out_data, out_data_n;
   logic              out_valid, out_valid_n;
   logic              rdy, rdy_n;

   logic [REM_W-1:0]  shifted;
   logic [REM_W-1:0]  diff;
   logic              fits;

   assign input_dividen_tready = rdy;
   assign input_divisor_tready = rdy;
   assign output_tdata         = out_data;
   assign output_tvalid        = out_valid;

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         dividend  <= '0;
         divisor   <= '0;
         rem       <= '0;
         quot      <= '0;
         cnt       <= '0;
         calc_done <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         rdy       <= 1'b0;
      end else begin
         state     <= state_n;
         dividend  <= dividend_n;
         divisor   <= divisor_n;
         rem       <= rem_n;
         quot      <= quot_n;
         cnt       <= cnt_n;
         calc_done <= calc_done_n;
         out_data  <= out_data_n;
         out_valid <= out_valid_n;
         rdy       <= rdy_n;
      end
   end

   // Next-state, division step and handshake outputs.
   always_comb begin
      state_n     = state;
      dividend_n  = dividend;
      divisor_n   = divisor;
      rem_n       = rem;
      quot_n      = quot;
      cnt_n       = cnt;
      calc_done_n = calc_done;
      out_data_n  = out_data;
      out_valid_n = out_valid;
      rdy_n       = rdy;

      // Remainder stays below the divisor, so dropping its top bit loses nothing.
      shifted = REM_W'({rem, dividend[SIZE-1]});
      diff    = shifted - {1'b0, divisor};
      fits    = (shifted >= {1'b0, divisor});

      case (state)
         IDLE: begin
            rdy_n = 1'b1;
            if (rdy && input_dividen_tvalid && input_divisor_tvalid) begin
               dividend_n  = input_dividen_tdata;
               divisor_n   = input_divisor_tdata;
               rem_n       = '0;
               quot_n      = '0;
               cnt_n       = CNT_W'(SIZE - 1);
               calc_done_n = 1'b0;
               rdy_n       = 1'b0;
               state_n     = CALC;
            end
         end
         CALC: begin
            rdy_n = 1'b0;
            if (calc_done) begin
               out_data_n  = quot;
               out_valid_n = 1'b1;
               state_n     = DONE;
            end else begin
               dividend_n = dividend << 1;
               rem_n      = fits ? diff : shifted;
               quot_n     = {quot[SIZE-2:0], fits};
               if (cnt == '0) begin
                  calc_done_n = 1'b1;
               end else begin
                  cnt_n = cnt - CNT_W'(1);
               end
            end
         end
         DONE: begin
            if (output_tready) begin
               out_valid_n = 1'b0;
               rdy_n       = 1'b1;
               state_n     = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_division.sv
// Directed-vector bench for the sequential divider.
module tb_division;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] dividen_data;
   logic        dividen_valid;
   logic        dividen_ready;
   logic [63:0] divisor_data;
   logic        divisor_valid;
   logic        divisor_ready;
   logic [63:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int vectors    = 0;
   int miscompares = 0;

   localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   division #(.SIZE(64)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .input_dividen_tdata  (dividen_data),
      .input_dividen_tvalid (dividen_valid),
      .input_dividen_tready (dividen_ready),
      .input_divisor_tdata  (divisor_data),
      .input_divisor_tvalid (divisor_valid),
      .input_divisor_tready (divisor_ready),
      .output_tdata         (out_data),
      .output_tvalid        (out_valid),
      .output_tready        (out_ready)
   );

   always #5 clk = ~clk;

   // Present operands, wait for acceptance, then count edges until tvalid.
   task automatic run_div(input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] q, output int lat);
      int w;
      dividen_data  = a;
      divisor_data  = b;
      dividen_valid = 1'b1;
      divisor_valid = 1'b1;
      w = 0;
      while (!(dividen_ready && divisor_ready) && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      dividen_valid = 1'b0;
      divisor_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      q = out_data;
   endtask

   task automatic test_reset;
      rst           = 1'b0;
      out_ready     = 1'b0;
      dividen_valid = 1'b0;
      divisor_valid = 1'b0;
      dividen_data  = '0;
      divisor_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({dividen_ready, divisor_ready, out_valid} !== 3'b000 || out_data !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy=%b%b vld=%b data=%0d, want 00 0 0",
                  dividen_ready, divisor_ready, out_valid, out_data);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({dividen_ready, divisor_ready, out_valid} !== 3'b110) begin
         miscompares++;
         $display("FAIL reset_release_idle: got rdy=%b%b vld=%b, want 11 0",
                  dividen_ready, divisor_ready, out_valid);
      end
   endtask

   task automatic test_reference;
      logic [63:0] q;
      int lat;
      out_ready = 1'b1;
      run_div(64'd20149227094288729, 64'd69814, q, lat);
      vectors++;
      if (q !== 64'd288612987284) begin
         miscompares++;
         $display("FAIL ref_quotient: got %0d want 288612987284", q);
      end
      vectors++;
      if (lat !== 65) begin
         miscompares++;
         $display("FAIL ref_latency: got %0d want 65", lat);
      end
      @(posedge clk); #1;
      vectors++;
      if ({dividen_ready, divisor_ready, out_valid} !== 3'b110) begin
         miscompares++;
         $display("FAIL ref_return_idle: got rdy=%b%b vld=%b, want 11 0",
                  dividen_ready, divisor_ready, out_valid);
      end
   endtask

   task automatic test_backpressure;
      logic [63:0] q;
      int lat;
      int bad;
      out_ready = 1'b0;
      run_div(64'd100, 64'd7, q, lat);
      vectors++;
      if (q !== 64'd14 || lat !== 65) begin
         miscompares++;
         $display("FAIL bp_result: got q=%0d lat=%0d want q=14 lat=65", q, lat);
      end
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_data !== 64'd14 || dividen_ready !== 1'b0) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({dividen_ready, divisor_ready, out_valid} !== 3'b110 || out_data !== 64'd14) begin
         miscompares++;
         $display("FAIL bp_release: got rdy=%b%b vld=%b data=%0d want 11 0 14",
                  dividen_ready, divisor_ready, out_valid, out_data);
      end
   endtask

   task automatic test_edges;
      logic [63:0] ea [5];
      logic [63:0] eb [5];
      logic [63:0] eq [5];
      logic [63:0] q;
      int lat;
      ea[0] = 64'd5;     eb[0] = 64'd9;     eq[0] = 64'd0;
      ea[1] = 64'd0;     eb[1] = 64'd3;     eq[1] = 64'd0;
      ea[2] = ALL_ONES;  eb[2] = 64'd1;     eq[2] = ALL_ONES;
      ea[3] = ALL_ONES;  eb[3] = ALL_ONES;  eq[3] = 64'd1;
      ea[4] = 64'd12345; eb[4] = 64'd0;     eq[4] = ALL_ONES;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         run_div(ea[i], eb[i], q, lat);
         vectors++;
         if (q !== eq[i] || lat !== 65) begin
            miscompares++;
            $display("FAIL edge_%0d: %0d/%0d got q=%0d lat=%0d want q=%0d lat=65",
                     i, ea[i], eb[i], q, lat, eq[i]);
         end
      end
   endtask

   task automatic test_gating;
      int w;
      int bad;
      int lat;
      out_ready = 1'b1;
      w = 0;
      while (!(dividen_ready && divisor_ready) && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      dividen_data  = 64'd5000;
      divisor_data  = 64'd50;
      dividen_valid = 1'b1;
      divisor_valid = 1'b0;
      bad = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (dividen_ready !== 1'b1 || divisor_ready !== 1'b1 || out_valid !== 1'b0) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL gate_single_valid: got %0d cycles not idle want 0", bad);
      end
      divisor_valid = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({dividen_ready, divisor_ready} !== 2'b00) begin
         miscompares++;
         $display("FAIL gate_accept: got rdy=%b%b want 00", dividen_ready, divisor_ready);
      end
      // Leave valids up with new data during the calculation; must be ignored.
      dividen_data = 64'd1;
      divisor_data = 64'd1;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      dividen_valid = 1'b0;
      divisor_valid = 1'b0;
      vectors++;
      if (out_data !== 64'd100 || lat !== 65) begin
         miscompares++;
         $display("FAIL gate_result: got q=%0d lat=%0d want q=100 lat=65", out_data, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      logic [63:0] q;
      int w;
      int lat;
      out_ready = 1'b1;
      w = 0;
      while (!(dividen_ready && divisor_ready) && w < 200) begin
         @(posedge clk); #1;
         w++;
      end
      dividen_data  = 64'd1000000;
      divisor_data  = 64'd7;
      dividen_valid = 1'b1;
      divisor_valid = 1'b1;
      @(posedge clk); #1;
      dividen_valid = 1'b0;
      divisor_valid = 1'b0;
      repeat (30) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      vectors++;
      if ({dividen_ready, divisor_ready, out_valid} !== 3'b000 || out_data !== 64'd0) begin
         miscompares++;
         $display("FAIL midreset_immediate: got rdy=%b%b vld=%b data=%0d want 00 0 0",
                  dividen_ready, divisor_ready, out_valid, out_data);
      end
      repeat (40) @(posedge clk);
      #1;
      vectors++;
      if ({dividen_ready, divisor_ready, out_valid} !== 3'b000 || out_data !== 64'd0) begin
         miscompares++;
         $display("FAIL midreset_held: got rdy=%b%b vld=%b data=%0d want 00 0 0",
                  dividen_ready, divisor_ready, out_valid, out_data);
      end
      rst = 1'b1;
      run_div(64'd1000, 64'd10, q, lat);
      vectors++;
      if (q !== 64'd100 || lat !== 65) begin
         miscompares++;
         $display("FAIL midreset_after: got q=%0d lat=%0d want q=100 lat=65", q, lat);
      end
   endtask

   task automatic test_back_to_back;
      logic [63:0] q;
      int lat;
      out_ready = 1'b1;
      run_div(64'd1000000, 64'd3, q, lat);
      vectors++;
      if (q !== 64'd333333 || lat !== 65) begin
         miscompares++;
         $display("FAIL b2b_first: got q=%0d lat=%0d want q=333333 lat=65", q, lat);
      end
      run_div(64'd81, 64'd9, q, lat);
      vectors++;
      if (q !== 64'd9 || lat !== 65) begin
         miscompares++;
         $display("FAIL b2b_second: got q=%0d lat=%0d want q=9 lat=65", q, lat);
      end
   endtask

   initial begin
      test_reset();
      test_reference();
      test_backpressure();
      test_edges();
      test_gating();
      test_reset_mid();
      test_back_to_back();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/division.md
Name: division

Overview:
- Sequential unsigned integer divider with AXI-Stream-style valid/ready handshakes.
- Accepts one dividend and one divisor, computes the quotient by restoring long division (one quotient bit per clock) and presents the quotient on a single output stream.
- Arithmetic helper inside the ElGamal datapath; a new operand pair is accepted only after the previous result has been delivered.

Parameters:
- SIZE, 64, bit width of the dividend, divisor and quotient.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = in reset).
- input_dividen_tdata  input  SIZE  dividend, unsigned.
- input_dividen_tvalid  input  1  dividend valid.
- input_dividen_tready  output  1  divider can accept the dividend.
- input_divisor_tdata  input  SIZE  divisor, unsigned.
- input_divisor_tvalid  input  1  divisor valid.
- input_divisor_tready  output  1  divider can accept the divisor.
- output_tdata  output  SIZE  quotient floor(dividend/divisor).
- output_tvalid  output  1  quotient valid.
- output_tready  input  1  downstream accepts the quotient.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; both input tready=0; output_tvalid=0; output_tdata=0; internal registers cleared. Outputs stay in these values for as long as rst is low.
- States: IDLE, CALC, DONE.
- IDLE:
  - input_dividen_tready=1 and input_divisor_tready=1.
  - Operands are accepted on the first rising edge where both tvalid are high. The two operands are taken together; one valid alone does nothing.
  - On acceptance: latch both operands, clear the partial remainder and the quotient, set the bit counter to SIZE-1, drop both treadys, go to CALC.
- CALC, one iteration per cycle, MSB first:
  - Shift the next dividend bit into the partial remainder. The partial remainder register is SIZE+1 bits wide so it never overflows.
  - If remainder >= divisor: subtract the divisor and set the quotient bit to 1; otherwise set it to 0.
  - After exactly SIZE iterations, go to DONE.
  - Both treadys stay 0 and output_tvalid stays 0 throughout CALC.
- DONE:
  - output_tvalid=1 and output_tdata=quotient, both held stable until output_tready=1 is sampled.
  - On that edge: output_tvalid drops to 0 and the state returns to IDLE, with treadys =1 from the next cycle.
  - output_tdata holds the last quotient until overwritten.
- Latency: output_tvalid rises SIZE+1 rising edges after the accepting edge (65 for SIZE=64).
- Throughput: one division per SIZE+3 cycles minimum, with output_tready held high.
- Divisor = 0: no exception. The restoring algorithm naturally yields a quotient of all ones (2^SIZE-1), delivered with normal timing.
- Dividend < divisor: quotient 0. Dividend = 0: quotient 0. Divisor = 1: quotient = dividend.
- output_tready high before output_tvalid has no effect. Input tvalids during CALC/DONE are ignored; data is not captured.
- Reset asserted mid-operation: the operation is abandoned immediately and the block returns to reset values; no partial result is ever output.
- Remainder is internal only and is not exported.

Test Plan:
- Reference vector: dividend=20149227094288729, divisor=69814, both valid, output_tready=1 after release of reset -> output_tvalid rises 65 cycles after acceptance with output_tdata=288612987284; treadys return high one cycle after output handshake.
- Backpressure: dividend=100, divisor=7, output_tready=0 -> output_tvalid=1 with output_tdata=14, held stable for 20 cycles; raise output_tready -> tvalid drops after one edge, block back in IDLE.
- Edge operands: 5/9 -> 0; 0/3 -> 0; 2^64-1 / 1 -> 2^64-1; 2^64-1 / 2^64-1 -> 1; x/0 with x=12345 -> 2^64-1.
- Handshake gating: dividend_tvalid=1, divisor_tvalid=0 for 10 cycles -> nothing accepted, treadys stay 1; then assert divisor_tvalid -> division starts. Changing input data during CALC does not alter the result.
- Reset mid-operation: pull rst low 30 cycles into CALC -> treadys=0, output_tvalid=0, output_tdata=0 immediately; after release, a new division 1000/10 -> 100.
- Back-to-back: two divisions with valids and output_tready held high, 1000000/3 then 81/9 -> outputs 333333 then 9, each with latency 65.
